// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Single-port frame-buffer arbiter. Shares one synchronous
//                16-bit-word RAM (four 4-bit pixels per word) between a VGA
//                read port, a GPU pixel-write port and a full-screen fill
//                engine.
//
//                The VGA port has absolute priority on every cycle. Pixel
//                writes are performed as a read-modify-write of the
//                containing word. The fill engine writes one word per
//                VGA-free cycle.
//
//  Ports
//    clk          : single clock, all logic on the rising edge
//    reset        : synchronous, active-high reset
//    vga_req      : VGA pixel read request (accepted every cycle it is high)
//    vga_addr     : VGA pixel address, [16:2] word, [1:0] nibble
//    vga_valid    : vga_pixel valid (two cycles after vga_req)
//    vga_pixel    : requested pixel, registered
//    wr_valid     : GPU pixel write request
//    wr_ready     : write accepted when wr_valid && wr_ready
//    wr_addr      : pixel write address, same packing as vga_addr
//    wr_pixel     : pixel value to write
//    clear_start  : one-cycle pulse, fill frame buffer with clear_color
//    clear_color  : fill value, sampled with clear_start
//    clear_busy   : fill in progress
//    clear_done   : pulses in the cycle the last fill word is written
//    mem_addr     : RAM word address
//    mem_we       : RAM word write enable
//    mem_wdata    : RAM write data
//    mem_rdata    : RAM read data, valid the cycle after the address
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        vga_req,
    input  logic [16:0] vga_addr,
    output logic        vga_valid,
    output logic [3:0]  vga_pixel,

    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [16:0] wr_addr,
    input  logic [3:0]  wr_pixel,

    input  logic        clear_start,
    input  logic [3:0]  clear_color,
    output logic        clear_busy,
    output logic        clear_done,

    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [14:0] c_LAST_WORD = 15'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched pixel-write request
    logic [14:0] r_wr_word;
    logic [1:0]  r_wr_nib;
    logic [3:0]  r_wr_pix;

    // Merged word parked while VGA holds the bus in MERGE
    logic [15:0] r_hold;

    // Fill engine
    logic [14:0] r_clr_cnt;
    logic [3:0]  r_clr_color;

    // VGA read pipeline: stage 1 tracks the request while the RAM is
    // reading, stage 2 is the registered output.
    logic        r_vga_p1_valid;
    logic [1:0]  r_vga_p1_nib;
    logic        r_vga_valid;
    logic [3:0]  r_vga_pixel;

    // Combinational bus and control strobes
    logic [14:0] w_addr;
    logic        w_we;
    logic [15:0] w_wdata;
    logic        w_accept;
    logic        w_clr_load;
    logic        w_clr_adv;
    logic        w_hold_load;
    logic        w_done;
    logic [15:0] w_merged;
    logic [3:0]  w_vga_sel;

    // ------------------------------------------------------------------------
    // Read data manipulation
    // ------------------------------------------------------------------------
    // Word just read with the latched nibble replaced by the new pixel.
    always_comb begin
        w_merged = mem_rdata;
        case (r_wr_nib)
            2'd0:    w_merged[3:0]   = r_wr_pix;
            2'd1:    w_merged[7:4]   = r_wr_pix;
            2'd2:    w_merged[11:8]  = r_wr_pix;
            default: w_merged[15:12] = r_wr_pix;
        endcase
    end

    // Nibble of the returning word requested by the VGA one cycle earlier.
    always_comb begin
        case (r_vga_p1_nib)
            2'd0:    w_vga_sel = mem_rdata[3:0];
            2'd1:    w_vga_sel = mem_rdata[7:4];
            2'd2:    w_vga_sel = mem_rdata[11:8];
            default: w_vga_sel = mem_rdata[15:12];
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state, bus ownership and control strobes
    // ------------------------------------------------------------------------
    // A VGA request owns the bus outright; every state below only touches the
    // bus in cycles without one, otherwise it simply waits.
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = 15'd0;
        w_we        = 1'b0;
        w_wdata     = 16'd0;
        w_accept    = 1'b0;
        w_clr_load  = 1'b0;
        w_clr_adv   = 1'b0;
        w_hold_load = 1'b0;
        w_done      = 1'b0;

        if (vga_req) begin
            w_addr = vga_addr[16:2];
        end

        case (r_state)
            S_IDLE: begin
                // Fill request wins over a simultaneous pixel write; the
                // write stays pending since wr_ready is low this cycle.
                if (clear_start) begin
                    w_clr_load  = 1'b1;
                    w_state_nxt = S_CLEAR;
                end else if (wr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RD;
                end
            end

            S_RD: begin
                if (!vga_req) begin
                    w_addr      = r_wr_word;
                    w_state_nxt = S_MERGE;
                end
            end

            S_MERGE: begin
                // Read data is only valid this one cycle, so if VGA takes the
                // bus the merged word must be parked in the hold register.
                if (!vga_req) begin
                    w_addr      = r_wr_word;
                    w_we        = 1'b1;
                    w_wdata     = w_merged;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_load = 1'b1;
                    w_state_nxt = S_WR;
                end
            end

            S_WR: begin
                if (!vga_req) begin
                    w_addr      = r_wr_word;
                    w_we        = 1'b1;
                    w_wdata     = r_hold;
                    w_state_nxt = S_IDLE;
                end
            end

            S_CLEAR: begin
                if (!vga_req) begin
                    w_addr    = r_clr_cnt;
                    w_we      = 1'b1;
                    w_wdata   = {4{r_clr_color}};
                    w_clr_adv = 1'b1;
                    if (r_clr_cnt == c_LAST_WORD) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_word   <= 15'd0;
            r_wr_nib    <= 2'd0;
            r_wr_pix    <= 4'd0;
            r_hold      <= 16'd0;
            r_clr_cnt   <= 15'd0;
            r_clr_color <= 4'd0;
        end else begin
            if (w_accept) begin
                r_wr_word <= wr_addr[16:2];
                r_wr_nib  <= wr_addr[1:0];
                r_wr_pix  <= wr_pixel;
            end
            if (w_hold_load) begin
                r_hold <= w_merged;
            end
            if (w_clr_load) begin
                r_clr_cnt   <= 15'd0;
                r_clr_color <= clear_color;
            end else if (w_clr_adv) begin
                r_clr_cnt <= r_clr_cnt + 15'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_p1_valid <= 1'b0;
            r_vga_p1_nib   <= 2'd0;
            r_vga_valid    <= 1'b0;
            r_vga_pixel    <= 4'd0;
        end else begin
            r_vga_p1_valid <= vga_req;
            r_vga_p1_nib   <= vga_addr[1:0];
            r_vga_valid    <= r_vga_p1_valid;
            if (r_vga_p1_valid) begin
                r_vga_pixel <= w_vga_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Outputs are forced to their idle values while reset is asserted so an
    // operation interrupted by reset never reaches the RAM in that cycle.
    assign mem_addr   = reset ? 15'd0 : w_addr;
    assign mem_we     = reset ? 1'b0  : w_we;
    assign mem_wdata  = reset ? 16'd0 : w_wdata;
    assign vga_valid  = reset ? 1'b0  : r_vga_valid;
    assign vga_pixel  = reset ? 4'd0  : r_vga_pixel;
    assign clear_busy = reset ? 1'b0  : (r_state == S_CLEAR);
    assign clear_done = reset ? 1'b0  : w_done;
    assign wr_ready   = (r_state == S_IDLE) && !clear_start;

endmodule
`default_nettype wire
